// File: rtl/temp_sched_pkg.sv
// Shared types and constants for the temperature-conversion scheduler.
package temp_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    OUT
  } sched_state_t;

  // Freezing point in Fahrenheit; smaller operands have no unsigned Celsius value.
  localparam int F_FREEZE = 32;

  // Default temperature width for both scales.
  localparam int TEMP_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_g+1, wrapping.
module rr_arbiter #(
  parameter int N_CH = 4,
  localparam int IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] last_g,
  output logic [N_CH-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Pick the first requester after the previous winner; last_g itself is tried last.
  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand     = (int'(last_g) + k) % N_CH;
      cand_idx = IDX_W'(cand);
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        idx             = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/temp_conv_sched.sv
// Round-robin scheduler sharing one registered F-to-C converter among N_CH channels.
module temp_conv_sched
  import temp_sched_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int W        = TEMP_W,
  parameter int CONV_LAT = 1,
  localparam int IDX_W   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N_CH-1:0]   req_valid,
  input  logic [N_CH*W-1:0] req_f,
  output logic [N_CH-1:0]   req_ready,
  output logic [W-1:0]      conv_f,
  input  logic [W-1:0]      conv_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDX_W-1:0]  res_ch,
  output logic [W-1:0]      res_c,
  output logic              res_uflow,
  output logic              busy
);

  // Counter holds CONV_LAT down to 0, so WAIT spans CONV_LAT+1 cycles.
  localparam int CNT_W = $clog2(CONV_LAT + 2);
  localparam logic [W-1:0] FREEZE = W'(F_FREEZE);

  sched_state_t     state;
  logic [IDX_W-1:0] last_g;
  logic [IDX_W-1:0] g_idx;
  logic [N_CH-1:0]  g_onehot;
  logic             g_any;
  logic [W-1:0]     g_f;
  logic [CNT_W-1:0] cnt;
  logic             uflow_q;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req    (req_valid),
    .last_g (last_g),
    .grant  (g_onehot),
    .idx    (g_idx),
    .any    (g_any)
  );

  assign g_f = req_f[g_idx*W +: W];

  // Grants are offered only while idle and out of reset; the handshake is the IDLE->WAIT edge.
  assign req_ready = (state == IDLE && !rstn) ? g_onehot : '0;

  // Scheduler FSM with registered result, status and operand outputs.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    if (rstn) begin
      state     <= IDLE;
      last_g    <= IDX_W'(N_CH - 1);
      conv_f    <= '0;
      res_ch    <= '0;
      res_c     <= '0;
      res_uflow <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      uflow_q   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (g_any) begin
            conv_f  <= g_f;
            res_ch  <= g_idx;
            last_g  <= g_idx;
            uflow_q <= (g_f < FREEZE);
            cnt     <= CNT_W'(CONV_LAT);
            busy    <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            res_c     <= conv_c;
            res_uflow <= uflow_q;
            res_valid <= 1'b1;
            state     <= OUT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_conv_sched.sv
// Self-checking bench for temp_conv_sched with behavioural converter models.
module tb_temp_conv_sched;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  // Default-latency DUT signals.
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_f     = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   conv_f, conv_c;
  logic           res_valid, res_uflow, busy;
  logic           res_ready = 1'b0;
  logic [IW-1:0]  res_ch;
  logic [W-1:0]   res_c;

  // CONV_LAT=3 DUT signals.
  logic [N-1:0]   req_valid_3 = '0;
  logic [N*W-1:0] req_f_3     = '0;
  logic [N-1:0]   req_ready_3;
  logic [W-1:0]   conv_f_3, conv_c_3;
  logic           res_valid_3, res_uflow_3, busy_3;
  logic           res_ready_3 = 1'b0;
  logic [IW-1:0]  res_ch_3;
  logic [W-1:0]   res_c_3;

  temp_conv_sched #(.N_CH(N), .W(W), .CONV_LAT(1)) u_dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_f(req_f), .req_ready(req_ready),
    .conv_f(conv_f), .conv_c(conv_c), .res_valid(res_valid), .res_ready(res_ready),
    .res_ch(res_ch), .res_c(res_c), .res_uflow(res_uflow), .busy(busy)
  );

  temp_conv_sched #(.N_CH(N), .W(W), .CONV_LAT(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid_3), .req_f(req_f_3), .req_ready(req_ready_3),
    .conv_f(conv_f_3), .conv_c(conv_c_3), .res_valid(res_valid_3), .res_ready(res_ready_3),
    .res_ch(res_ch_3), .res_c(res_c_3), .res_uflow(res_uflow_3), .busy(busy_3)
  );

  // Reference converter: truncating (F-32)*5/9, zero below freezing.
  function automatic logic [7:0] f2c(input logic [7:0] f);
    if (f < 8'd32) return 8'd0;
    return 8'(((int'(f) - 32) * 5) / 9);
  endfunction

  always @(posedge clk) conv_c <= f2c(conv_f);

  logic [7:0] pipe3 [3];
  always @(posedge clk) begin
    pipe3[0] <= f2c(conv_f_3);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign conv_c_3 = pipe3[2];

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int onehot2idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Waits (bounded) for res_valid on the default DUT; returns cycles waited.
  task automatic wait_res(output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 20) begin
      @(negedge clk); #1;
      cyc++;
    end
  endtask

  task automatic accept();
    @(negedge clk); res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
  endtask

  // One isolated request on a single channel, checked end to end.
  task automatic run_one(input string tag, input int ch, input int f, input int exp_c, input bit exp_uf);
    int lat;
    logic [7:0] f8;
    f8 = 8'(f);
    @(negedge clk);
    req_f[ch*W +: W] = f8;
    req_valid        = 4'(1 << ch);
    #1;
    check({tag, "_grant"}, req_ready, 32'(1 << ch));
    @(negedge clk);
    req_valid = '0;
    #1;
    check({tag, "_conv_f"}, conv_f, f8);
    wait_res(lat);
    check({tag, "_latency"}, lat + 1, 3);
    check({tag, "_conv_f_held"}, conv_f, f8);
    check({tag, "_res_ch"}, res_ch, ch);
    if (!exp_uf) check({tag, "_res_c"}, res_c, exp_c);
    check({tag, "_res_uflow"}, res_uflow, exp_uf);
    @(negedge clk); res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
    #1;
    check({tag, "_valid_drop"}, res_valid, 0);
    check({tag, "_busy_drop"}, busy, 0);
  endtask

  typedef struct {
    int ch;
    int f;
    int exp_c;
    bit exp_uf;
  } vec_t;

  vec_t vecs [6];

  initial begin : main
    int lat, bad;
    int g_ch[$], g_cyc[$], r_ch[$], r_c[$];
    int exp_res[4];
    logic [N-1:0] clr;

    vecs[0] = '{ch: 0, f: 159, exp_c: 70,  exp_uf: 1'b0};
    vecs[1] = '{ch: 2, f: 20,  exp_c: 0,   exp_uf: 1'b1};
    vecs[2] = '{ch: 3, f: 32,  exp_c: 0,   exp_uf: 1'b0};
    vecs[3] = '{ch: 1, f: 31,  exp_c: 0,   exp_uf: 1'b1};
    vecs[4] = '{ch: 1, f: 255, exp_c: 123, exp_uf: 1'b0};
    vecs[5] = '{ch: 3, f: 212, exp_c: 100, exp_uf: 1'b0};
    exp_res = '{82, 37, 93, 100};

    // Reset with requests pending: nothing may be offered.
    req_valid = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_conv_f", conv_f, 0);
    check("rst_res_ch", res_ch, 0);
    check("rst_res_c", res_c, 0);
    check("rst_res_uflow", res_uflow, 0);
    @(negedge clk);
    rstn      = 1'b0;
    req_valid = '0;

    // Isolated single-channel vectors.
    for (int i = 0; i < 6; i++)
      run_one($sformatf("vec%0d", i), vecs[i].ch, vecs[i].f, vecs[i].exp_c, vecs[i].exp_uf);

    // All channels continuously requesting with res_ready high: fair order, 4-cycle spacing.
    @(negedge clk);
    req_f     = {8'd212, 8'd200, 8'd100, 8'd180};
    res_ready = 1'b1;
    req_valid = 4'hF;
    for (int cyc = 0; cyc < 24; cyc++) begin
      #1;
      clr = '0;
      if (req_ready != '0) begin
        g_ch.push_back(onehot2idx(req_ready));
        g_cyc.push_back(cyc);
        clr = req_ready;
      end
      if (res_valid) begin
        r_ch.push_back(int'(res_ch));
        r_c.push_back(int'(res_c));
      end
      @(negedge clk);
      req_valid = req_valid & ~clr;
    end
    res_ready = 1'b0;
    check("rr_grant_count", g_ch.size(), 4);
    check("rr_result_count", r_ch.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < g_ch.size()) begin
        check($sformatf("rr_grant%0d_ch", i), g_ch[i], i);
        if (i > 0) check($sformatf("rr_grant%0d_gap", i), g_cyc[i] - g_cyc[i-1], 4);
      end
      if (i < r_ch.size()) begin
        check($sformatf("rr_res%0d_ch", i), r_ch[i], i);
        check($sformatf("rr_res%0d_c", i), r_c[i], exp_res[i]);
      end
    end

    // Consumer stalls in OUT while ch1 waits.
    @(negedge clk);
    req_f[0*W +: W] = 8'd100;
    req_valid       = 4'b0001;
    #1;
    check("stall_grant0", req_ready, 4'b0001);
    @(negedge clk);
    req_f[1*W +: W] = 8'd50;
    req_valid       = 4'b0010;
    #1;
    wait_res(lat);
    check("stall_res_valid", res_valid, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (res_c !== 8'd37 || res_ch !== 2'd0 || req_ready !== '0 || res_valid !== 1'b1) bad++;
    end
    check("stall_stable_cycles_bad", bad, 0);
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    check("stall_handshake_no_grant", req_ready, 0);
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    check("stall_release_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    #1;
    wait_res(lat);
    check("stall_ch1_res_ch", res_ch, 1);
    check("stall_ch1_res_c", res_c, 10);
    accept();

    // Reset in the second WAIT cycle drops the sample and re-favours ch0.
    @(negedge clk);
    req_f[0*W +: W] = 8'd100;
    req_f[1*W +: W] = 8'd200;
    req_valid       = 4'b0001;
    #1;
    check("rstw_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    req_valid = 4'b0011;
    #1;
    check("rstw_busy", busy, 0);
    check("rstw_res_valid", res_valid, 0);
    check("rstw_conv_f", conv_f, 0);
    check("rstw_req_ready_in_rst", req_ready, 0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rstw_regrant_ch0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    #1;
    wait_res(lat);
    check("rstw_res_ch", res_ch, 0);
    check("rstw_res_c", res_c, 37);
    accept();

    // CONV_LAT=3 build: 4 WAIT cycles with operand held, result 5 cycles after handshake.
    @(negedge clk);
    req_f_3[1*W +: W] = 8'd212;
    req_valid_3       = 4'b0010;
    #1;
    check("lat3_grant", req_ready_3, 4'b0010);
    bad = 0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) req_valid_3 = '0;
      #1;
      if (conv_f_3 !== 8'd212 || res_valid_3 !== 1'b0 || busy_3 !== 1'b1) bad++;
    end
    check("lat3_wait_hold_bad", bad, 0);
    lat = 4;
    do begin
      @(negedge clk); #1;
      lat++;
    end while (!res_valid_3 && lat < 16);
    check("lat3_latency", lat, 5);
    check("lat3_res_ch", res_ch_3, 1);
    check("lat3_res_c", res_c_3, 100);
    check("lat3_res_uflow", res_uflow_3, 0);
    @(negedge clk); res_ready_3 = 1'b1;
    @(negedge clk); res_ready_3 = 1'b0;
    #1;
    check("lat3_valid_drop", res_valid_3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule

// File: doc/temp_conv_sched.md
# temp_conv_sched

Round-robin scheduler that shares one Fahrenheit-to-Celsius converter (`F_to_C`, registered output) between `N_CH` temperature-sample requesters. It sits between the sensor-channel front ends and the converter. It grants one request at a time and holds the Fahrenheit operand stable for the converter's latency. It then returns the Celsius result, tagged with its channel, over a valid/ready handshake.

## Interface
- `N_CH`, default 4: number of requesting channels (2..8)
- `W`, default 8: temperature width, Fahrenheit and Celsius
- `CONV_LAT`, default 1: converter latency in clock edges, from operand change to valid `celsius`
- `clk`  in  1: single clock; everything is on the rising edge
- `rstn`  in  1: synchronous, active-high reset; asserted = 1
- `req_valid`  in  N_CH: channel i has a sample pending
- `req_f`  in  N_CH*W: channel i operand at bits `[i*W +: W]`; held stable while `req_valid[i]` is high
- `req_ready`  out  N_CH: one-hot; a handshake occurs on channel i when `req_valid[i] & req_ready[i]`
- `conv_f`  out  W: operand driven to the converter's `temp_in_F`
- `conv_c`  in  W: the converter's `celsius` output
- `res_valid`  out  1: result available
- `res_ready`  in  1: consumer accepts the result
- `res_ch`  out  $clog2(N_CH): channel that owns the result
- `res_c`  out  W: captured Celsius value
- `res_uflow`  out  1: operand was below 32 °F, so the Celsius value is not representable and `res_c` is invalid
- `busy`  out  1: high in any state other than IDLE

## Operation
- FSM states: IDLE, WAIT, OUT.
- **IDLE**
  - If any `req_valid` is high, the round-robin pick `g` is chosen.
  - The search starts at `(last_g+1) mod N_CH` and wraps.
  - `req_ready[g]` is 1 for this cycle only, combinationally.
  - On the edge: `conv_f <= req_f[g]`, `res_ch <= g`, `last_g <= g`, `uflow_q <= (req_f[g] < 32)`, counter loads `CONV_LAT`, next state is WAIT.
  - With no request pending, the block stays in IDLE and `req_ready` is 0.
- **WAIT**
  - `conv_f` is held. The counter decrements each cycle, so WAIT lasts `CONV_LAT+1` cycles.
  - On the edge closing the last WAIT cycle: `res_c <= conv_c`, `res_uflow <= uflow_q`, next state is OUT.
- **OUT**
  - `res_valid` is 1, and `res_c`, `res_ch` and `res_uflow` are stable until the handshake.
  - On `res_ready`, next state is IDLE and `res_valid` drops on the following cycle.
  - No new grant is issued in the handshake cycle.
- `req_ready` is 0 in WAIT and OUT. Requests arriving then wait; they are never lost, because requesters hold `req_valid`.
- Arithmetic: the scheduler does no conversion. The only comparison is the unsigned `W`-bit test against 32. Operands of 32..255 pass through unchanged.
- **Reset** (any state, including mid-WAIT or mid-OUT): the in-flight sample is dropped and next state is IDLE.
  - `last_g <= N_CH-1`, so channel 0 is favoured first.
  - `req_ready`=0 while `rstn`=1.
  - `conv_f`=0, `res_valid`=0, `res_ch`=0, `res_c`=0, `res_uflow`=0, `busy`=0.

## Timing
- Request handshake in cycle t → `res_valid` first high in cycle t+`CONV_LAT`+2. With the default, that is t+3.
- Minimum spacing between grants is `CONV_LAT`+3 cycles. With `res_ready` tied high, that is 4 cycles.
- `conv_f` changes only on the edge that leaves IDLE and is constant through WAIT and OUT.
- When `req_valid` and `res_ready` are high simultaneously in OUT, the result is accepted first; the request is granted in the next IDLE cycle.
- With `res_ready` held low, OUT is held indefinitely and all requesters stall.
- Fairness: with all channels requesting continuously, grants cycle 0,1,…,N_CH-1,0. No channel waits more than `N_CH`-1 grants.

## Structure
- Package `temp_sched_pkg` holds:
  - the state enum `sched_state_t` (IDLE, WAIT, OUT);
  - the localparam `F_FREEZE = 32`;
  - the default width `TEMP_W = 8`.
- Sub-module `rr_arbiter`:
  - combinational;
  - inputs: request vector and `last_g`;
  - outputs: one-hot grant, encoded index and `any`.
- FSM, counter and result registers live in `temp_conv_sched`. The top level instantiates `F_to_C` alongside it.

## Test plan
- Reset, then `req_valid`=0001 with ch0 `req_f`=159 → `req_ready`=0001 for 1 cycle; `res_valid` 3 cycles later; `res_ch`=0, `res_c`=70 (converter output); `res_uflow`=0.
- All four channels valid, with `req_f` = 180/100/200/212 and `res_ready`=1 → grants in order 0,1,2,3, spaced 4 cycles apart; results 82, 37, 93, 100 tagged 0..3.
- ch2 `req_f`=20 → `res_uflow`=1, `res_ch`=2.
- `res_ready` held low for 10 cycles in OUT, with ch1 requesting → `res_c` is stable and `req_ready` stays 0. After release, ch1 is granted in the next IDLE cycle.
- `rstn`=1 pulsed in the second WAIT cycle → next cycle: `busy`=0, `res_valid`=0, `conv_f`=0. The following grant goes to ch0 even if ch0 was the dropped channel.
- `CONV_LAT`=3 build → handshake-to-`res_valid` is 5 cycles and `conv_f` is held for 4 WAIT cycles.
